execute_unit_multicycle: RTL

Parametrised, registered successor to the combinational execute stage. It performs single-cycle ALU/branch/jump operations, pipelined multiplies and iterative divides behind a valid/ready handshake. Branch and jump resolution is registered. The block sits between the decode/register-read stage and the memory stage, and a flush port lets the hazard unit kill the operation in flight.

---
 rtl/execute_unit_multicycle.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_unit_multicycle.sv
// execute_unit_multicycle
//   Registered execute stage. Single-cycle ALU / branch / jump / LINK ops,
//   a fixed-latency multiply and an iterative restoring divider, one op in
//   flight at a time behind a valid/ready handshake.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   flush               kill the in-flight op and drop any same-cycle input
//   in_valid/in_ready   input handshake (in_ready only in IDLE)
//   op_class, func3,
//   alt_op, branch,
//   jump, src1_sel,
//   src2_sel            operation decode
//   data1, data2, pc,
//   imm                 operands
//   out_valid           one-cycle pulse, result fields valid
//   result              ALU/MUL/DIV/LINK result
//   branch_taken/target redirect request, held while out_valid=0
module execute_unit_multicycle #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op_class,
  input  logic [2:0]      func3,
  input  logic            alt_op,
  input  logic            branch,
  input  logic            jump,
  input  logic            src1_sel,
  input  logic            src2_sel,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic [XLEN-1:0] target
);
  localparam int SHW = $clog2(XLEN);
  localparam int DCW = $clog2(XLEN + 1);
  localparam int MCW = $clog2(MUL_STAGES + 1);

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_MUL  = 2'b01;
  localparam logic [1:0] CLS_DIV  = 2'b10;
  localparam logic [1:0] CLS_LINK = 2'b11;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;
  state_t state, state_nxt;

  // operands and shared adders
  logic [XLEN-1:0] a_op, b_op, sum, link_pc, br_tgt, jump_tgt, sra_res;
  assign a_op     = src1_sel ? pc  : data1;
  assign b_op     = src2_sel ? imm : data2;
  assign sum      = a_op + b_op;
  assign link_pc  = pc + XLEN'(4);
  assign br_tgt   = pc + imm;
  assign jump_tgt = {sum[XLEN-1:1], 1'b0};
  assign sra_res  = $signed(a_op) >>> b_op[SHW-1:0];

  // ALU
  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (func3)
      3'b000:  alu_res = alt_op ? (a_op - b_op) : sum;
      3'b001:  alu_res = a_op << b_op[SHW-1:0];
      3'b010:  alu_res = XLEN'($signed(a_op) < $signed(b_op));
      3'b011:  alu_res = XLEN'(a_op < b_op);
      3'b100:  alu_res = a_op ^ b_op;
      3'b101:  alu_res = alt_op ? sra_res : (a_op >> b_op[SHW-1:0]);
      3'b110:  alu_res = a_op | b_op;
      default: alu_res = a_op & b_op;
    endcase
  end

  // branch compare always uses the register operands
  logic br_cond;
  always_comb begin
    br_cond = 1'b0;
    case (func3)
      3'b000:  br_cond = (data1 == data2);
      3'b001:  br_cond = (data1 != data2);
      3'b100:  br_cond = ($signed(data1) <  $signed(data2));
      3'b101:  br_cond = ($signed(data1) >= $signed(data2));
      3'b110:  br_cond = (data1 <  data2);
      3'b111:  br_cond = (data1 >= data2);
      default: br_cond = 1'b0;
    endcase
  end

  // multiply: extending both operands to 2*XLEN makes the low 2*XLEN bits
  // of a plain product correct for every signedness combination
  logic                 a_sx, b_sx;
  logic [2*XLEN-1:0]    mul_a, mul_b, prod;
  logic [XLEN-1:0]      mul_res;
  assign a_sx    = (func3[1:0] == 2'b01 || func3[1:0] == 2'b10) && a_op[XLEN-1];
  assign b_sx    = (func3[1:0] == 2'b01) && b_op[XLEN-1];
  assign mul_a   = {{XLEN{a_sx}}, a_op};
  assign mul_b   = {{XLEN{b_sx}}, b_op};
  assign prod    = mul_a * mul_b;
  assign mul_res = (func3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // divide operand prep and one-cycle special cases
  logic            div_signed, div_rem, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, div_spec_res;
  assign div_signed   = ~func3[0];
  assign div_rem      = func3[1];
  assign a_neg        = div_signed && a_op[XLEN-1];
  assign b_neg        = div_signed && b_op[XLEN-1];
  assign a_mag        = a_neg ? -a_op : a_op;
  assign b_mag        = b_neg ? -b_op : b_op;
  assign div_zero     = (b_op == '0);
  assign div_ovf      = div_signed && (a_op == XMIN) && (b_op == '1);
  // overflow quotient is MIN, which is the dividend itself
  assign div_spec_res = div_zero ? (div_rem ? a_op : '1) : (div_rem ? '0 : a_op);

  // restoring divider: quo_r shifts dividend bits out and quotient bits in
  logic [XLEN-1:0] rem_r, quo_r, dvs_r, rem_step, quo_step, div_fin;
  logic [XLEN:0]   shifted, diff;
  logic            q_neg_r, r_neg_r, rem_sel_r;
  logic [DCW-1:0]  div_cnt;
  assign shifted  = {rem_r, quo_r[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs_r};
  assign rem_step = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_step = {quo_r[XLEN-2:0], ~diff[XLEN]};
  assign div_fin  = rem_sel_r ? (r_neg_r ? -rem_step : rem_step)
                              : (q_neg_r ? -quo_step : quo_step);

  logic [XLEN-1:0] mul_r;
  logic [MCW-1:0]  mul_cnt;

  // decode / handshake
  logic is_redirect, mul_multi, div_multi, accept, mul_done, div_done;
  assign in_ready    = (state == IDLE);
  assign accept      = in_valid && in_ready && !flush;
  assign is_redirect = branch || jump;
  assign mul_multi   = !is_redirect && (op_class == CLS_MUL) && (MUL_STAGES > 1);
  assign div_multi   = !is_redirect && (op_class == CLS_DIV) && !div_zero && !div_ovf;
  assign mul_done    = (state == MUL_BUSY) && (mul_cnt == MCW'(1));
  assign div_done    = (state == DIV_BUSY) && (div_cnt == DCW'(1));

  // single-cycle result; jump wins over branch
  logic [XLEN-1:0] single_res, single_tgt;
  logic            single_taken;
  always_comb begin
    single_res   = alu_res;
    single_tgt   = target;
    single_taken = 1'b0;
    if (jump) begin
      single_res   = link_pc;
      single_tgt   = jump_tgt;
      single_taken = 1'b1;
    end else if (branch) begin
      single_tgt   = br_tgt;
      single_taken = br_cond;
    end else begin
      case (op_class)
        CLS_ALU:  single_res = alu_res;
        CLS_MUL:  single_res = mul_res;
        CLS_DIV:  single_res = div_spec_res;
        CLS_LINK: single_res = link_pc;
        default:  single_res = alu_res;
      endcase
    end
  end

  // FSM
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && mul_multi)      state_nxt = MUL_BUSY;
          else if (accept && div_multi) state_nxt = DIV_BUSY;
        end
        MUL_BUSY: if (mul_done) state_nxt = IDLE;
        DIV_BUSY: if (div_done) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // datapath
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid    <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
      target       <= '0;
      mul_r        <= '0;
      mul_cnt      <= '0;
      rem_r        <= '0;
      quo_r        <= '0;
      dvs_r        <= '0;
      q_neg_r      <= 1'b0;
      r_neg_r      <= 1'b0;
      rem_sel_r    <= 1'b0;
      div_cnt      <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!flush) begin
        if (accept) begin
          if (mul_multi) begin
            mul_r   <= mul_res;
            mul_cnt <= MCW'(MUL_STAGES - 1);
          end else if (div_multi) begin
            rem_r     <= '0;
            quo_r     <= a_mag;
            dvs_r     <= b_mag;
            q_neg_r   <= a_neg ^ b_neg;
            r_neg_r   <= a_neg;
            rem_sel_r <= div_rem;
            div_cnt   <= DCW'(XLEN);
          end else begin
            out_valid    <= 1'b1;
            result       <= single_res;
            branch_taken <= single_taken;
            target       <= single_tgt;
          end
        end
        if (state == MUL_BUSY) begin
          mul_cnt <= mul_cnt - MCW'(1);
          if (mul_done) begin
            out_valid    <= 1'b1;
            result       <= mul_r;
            branch_taken <= 1'b0;
          end
        end
        if (state == DIV_BUSY) begin
          rem_r   <= rem_step;
          quo_r   <= quo_step;
          div_cnt <= div_cnt - DCW'(1);
          if (div_done) begin
            out_valid    <= 1'b1;
            result       <= div_fin;
            branch_taken <= 1'b0;
          end
        end
      end
    end
  end
endmodule
